// File: rtl/shot_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : shot_sequencer
// Description : Basketball shot simulator game controller: physics tick,
//               button debounce, engine handshake, basket detection, scoring.
//               Optional feature macro: AUTO_RELEASE_EN (forced release after
//               CHARGE_MAX ticks of charging).
// Revision    : 1.0 - initial release
// ============================================================================
module shot_sequencer #(
    parameter int TICK_DIV   = 1666667,
    parameter int DEB_TICKS  = 3,
    parameter int SHOT_TICKS = 600,
    parameter int HOLD_TICKS = 60,
    parameter int MAX_SHOTS  = 10,
    parameter int HOOP_X_L   = 610,
    parameter int HOOP_X_R   = 630,
    parameter int HOOP_Y     = 256
`ifdef AUTO_RELEASE_EN
    ,
    parameter int CHARGE_MAX = 120
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    input  logic       engine_done,
    output logic       tick,
    output logic       engine_btn,
    output logic       engine_rst,
    output logic       score_pulse,
    output logic [7:0] makes,
    output logic [7:0] attempts,
    output logic [2:0] phase
);

    localparam int c_TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_DEB_W  = $clog2(DEB_TICKS + 1);
    localparam int c_SHOT_W = $clog2(SHOT_TICKS + 1);
    localparam int c_HOLD_W = $clog2(HOLD_TICKS + 1);

    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_DIV - 1);
    localparam logic [c_DEB_W-1:0]  c_DEB_LAST  = c_DEB_W'(DEB_TICKS - 1);
    localparam logic [c_SHOT_W-1:0] c_SHOT_LAST = c_SHOT_W'(SHOT_TICKS - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_TICKS - 1);
    localparam logic [9:0]          c_X_MIN     = 10'(HOOP_X_L + 4);
    localparam logic [9:0]          c_X_MAX     = 10'(HOOP_X_R - 4);
    localparam logic [9:0]          c_HOOP_Y    = 10'(HOOP_Y);
    localparam logic [7:0]          c_MAX_SHOTS = 8'(MAX_SHOTS);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ARMED     = 3'd1,
        S_FLIGHT    = 3'd2,
        S_SCORED    = 3'd3,
        S_MISS      = 3'd4,
        S_GAME_OVER = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_TICK_W-1:0]   r_tick_cnt;
    logic                  r_tick;
    logic [1:0]            r_sync;
    logic                  r_btn_clean;
    logic [c_DEB_W-1:0]    r_deb_cnt;
    logic [c_SHOT_W-1:0]   r_flight_cnt;
    logic [c_HOLD_W-1:0]   r_hold_cnt;
    logic [9:0]            r_prev_y;
    logic [7:0]            r_makes;
    logic [7:0]            r_attempts;
    logic                  r_score_pulse;
    logic                  r_engine_rst;

    logic                  w_deb_flip;
    logic                  w_press;
    logic                  w_release;
    logic                  w_cross;
    logic                  w_launch;
    logic                  w_score;
    logic                  w_game_clear;
    logic                  w_in_hold;

    // ------------------------------------------------------------------
    // Physics tick: free-running, period exactly TICK_DIV clocks
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt <= '0;
            r_tick     <= 1'b0;
        end else begin
            r_tick <= (r_tick_cnt == c_TICK_LAST);
            if (r_tick_cnt == c_TICK_LAST) begin
                r_tick_cnt <= '0;
            end else begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Button synchronizer and tick-sampled debouncer
    // ------------------------------------------------------------------
    assign w_deb_flip = r_tick && (r_sync[1] != r_btn_clean) && (r_deb_cnt == c_DEB_LAST);
    assign w_press    = w_deb_flip && !r_btn_clean;
    assign w_release  = w_deb_flip &&  r_btn_clean;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync      <= 2'b00;
            r_btn_clean <= 1'b0;
            r_deb_cnt   <= '0;
        end else begin
            r_sync <= {r_sync[0], btn_raw};
            if (r_tick) begin
                if (r_sync[1] == r_btn_clean) begin
                    r_deb_cnt <= '0;
                end else if (r_deb_cnt == c_DEB_LAST) begin
                    r_btn_clean <= ~r_btn_clean;
                    r_deb_cnt   <= '0;
                end else begin
                    r_deb_cnt <= r_deb_cnt + 1'b1;
                end
            end
        end
    end

`ifdef AUTO_RELEASE_EN
    localparam int                 c_CHG_W    = $clog2(CHARGE_MAX + 1);
    localparam logic [c_CHG_W-1:0] c_CHG_LAST = c_CHG_W'(CHARGE_MAX - 1);

    logic [c_CHG_W-1:0] r_charge_cnt;
    logic               w_force_release;

    // Still held here means no release on this tick; release wins if both occur
    assign w_force_release = r_tick && (r_state == S_ARMED) && !w_release
                             && r_btn_clean && (r_charge_cnt == c_CHG_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_charge_cnt <= '0;
        end else if (r_state != S_ARMED) begin
            r_charge_cnt <= '0;
        end else if (r_tick) begin
            r_charge_cnt <= r_charge_cnt + 1'b1;
        end
    end
`else
    logic w_force_release;
    assign w_force_release = 1'b0;
`endif

    // Crossing the rim plane downward inside the rim, with a 4-pixel margin
    assign w_cross = (r_prev_y < c_HOOP_Y) && (ball_y >= c_HOOP_Y)
                     && (ball_x >= c_X_MIN) && (ball_x <= c_X_MAX);

    assign w_in_hold = (r_state == S_SCORED) || (r_state == S_MISS);

    // ------------------------------------------------------------------
    // Game FSM: next-state and transition strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_launch     = 1'b0;
        w_score      = 1'b0;
        w_game_clear = 1'b0;
        if (r_tick) begin
            case (r_state)
                S_IDLE: begin
                    if (w_press) begin
                        w_state_nxt = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (w_release || w_force_release) begin
                        w_state_nxt = S_FLIGHT;
                        w_launch    = 1'b1;
                    end
                end
                S_FLIGHT: begin
                    if (w_cross) begin
                        w_state_nxt = S_SCORED;
                        w_score     = 1'b1;
                    end else if (engine_done || (r_flight_cnt == c_SHOT_LAST)) begin
                        w_state_nxt = S_MISS;
                    end
                end
                S_SCORED, S_MISS: begin
                    if (r_hold_cnt == c_HOLD_LAST) begin
                        w_state_nxt = (r_attempts == c_MAX_SHOTS) ? S_GAME_OVER : S_IDLE;
                    end
                end
                S_GAME_OVER: begin
                    if (w_press) begin
                        w_state_nxt  = S_IDLE;
                        w_game_clear = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_engine_rst  <= 1'b1;
            r_score_pulse <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_engine_rst  <= (w_state_nxt == S_SCORED) || (w_state_nxt == S_MISS)
                             || (w_state_nxt == S_GAME_OVER);
            r_score_pulse <= w_score;
        end
    end

    // ------------------------------------------------------------------
    // Flight tracking: timer and previous-y for crossing detection
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flight_cnt <= '0;
            r_prev_y     <= '0;
        end else if (w_launch) begin
            r_flight_cnt <= '0;
            r_prev_y     <= ball_y;
        end else if (r_tick && (r_state == S_FLIGHT)) begin
            r_flight_cnt <= r_flight_cnt + 1'b1;
            r_prev_y     <= ball_y;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_cnt <= '0;
        end else if (!w_in_hold) begin
            r_hold_cnt <= '0;
        end else if (r_tick) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Score counters, saturating at 255
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_makes    <= '0;
            r_attempts <= '0;
        end else if (w_game_clear) begin
            r_makes    <= '0;
            r_attempts <= '0;
        end else begin
            if (w_launch && (r_attempts != 8'hFF)) begin
                r_attempts <= r_attempts + 1'b1;
            end
            if (w_score && (r_makes != 8'hFF)) begin
                r_makes <= r_makes + 1'b1;
            end
        end
    end

    assign tick        = r_tick;
    assign engine_btn  = (r_state == S_ARMED) && r_btn_clean;
    assign engine_rst  = r_engine_rst;
    assign score_pulse = r_score_pulse;
    assign makes       = r_makes;
    assign attempts    = r_attempts;
    assign phase       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_shot_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_shot_sequencer
// Description : Directed self-checking bench for shot_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shot_sequencer;

    localparam int TICK_DIV   = 10;
    localparam int DEB_TICKS  = 3;
    localparam int SHOT_TICKS = 20;
    localparam int HOLD_TICKS = 4;
    localparam int MAX_SHOTS  = 2;
`ifdef AUTO_RELEASE_EN
    localparam int CHARGE_MAX = 5;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_raw;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       engine_done;
    logic       tick;
    logic       engine_btn;
    logic       engine_rst;
    logic       score_pulse;
    logic [7:0] makes;
    logic [7:0] attempts;
    logic [2:0] phase;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    shot_sequencer #(
        .TICK_DIV   (TICK_DIV),
        .DEB_TICKS  (DEB_TICKS),
        .SHOT_TICKS (SHOT_TICKS),
        .HOLD_TICKS (HOLD_TICKS),
        .MAX_SHOTS  (MAX_SHOTS),
        .HOOP_X_L   (610),
        .HOOP_X_R   (630),
        .HOOP_Y     (256)
`ifdef AUTO_RELEASE_EN
        ,
        .CHARGE_MAX (CHARGE_MAX)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .ball_x      (ball_x),
        .ball_y      (ball_y),
        .engine_done (engine_done),
        .tick        (tick),
        .engine_btn  (engine_btn),
        .engine_rst  (engine_rst),
        .score_pulse (score_pulse),
        .makes       (makes),
        .attempts    (attempts),
        .phase       (phase)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to the next tick cycle (sampled on negedge), bounded
    task automatic next_tick();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tick !== 1'b1 && n < 4 * TICK_DIV);
        if (tick !== 1'b1) check("tick_timeout", {31'b0, tick}, 32'd1);
    endtask

    // Let n ticks take effect; leaves us one clock after the last tick
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            next_tick();
            @(negedge clk);
        end
    endtask

    task automatic press();
        btn_raw = 1'b1;
        step(DEB_TICKS);
    endtask

    task automatic release_btn();
        btn_raw = 1'b0;
        step(DEB_TICKS);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst         = 1'b1;
        btn_raw     = 1'b0;
        ball_x      = 10'd0;
        ball_y      = 10'd100;
        engine_done = 1'b0;
        repeat (5) @(negedge clk);

        check("rst_tick",        {31'b0, tick},        32'd0);
        check("rst_engine_btn",  {31'b0, engine_btn},  32'd0);
        check("rst_engine_rst",  {31'b0, engine_rst},  32'd1);
        check("rst_score_pulse", {31'b0, score_pulse}, 32'd0);
        check("rst_makes",       {24'b0, makes},       32'd0);
        check("rst_attempts",    {24'b0, attempts},    32'd0);
        check("rst_phase",       {29'b0, phase},       32'd0);
        rst = 1'b0;

        // Tick period and width
        next_tick();
        @(negedge clk);
        check("tick_width", {31'b0, tick}, 32'd0);
        check("idle_engine_rst", {31'b0, engine_rst}, 32'd0);
        n = 1;
        while (tick !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("tick_period", n, TICK_DIV);

        // Bouncy button never arms
        for (int i = 0; i < 3; i++) begin
            btn_raw = 1'b1;
            step(1);
            btn_raw = 1'b0;
            step(1);
        end
        check("bounce_phase", {29'b0, phase}, 32'd0);

        // Steady press: accepted on third sample
        btn_raw = 1'b1;
        step(DEB_TICKS - 1);
        check("deb_short_phase", {29'b0, phase}, 32'd0);
        step(1);
        check("armed_phase",      {29'b0, phase},      32'd1);
        check("armed_engine_btn", {31'b0, engine_btn}, 32'd1);

        // Shot 1: made basket
        ball_x = 10'd620;
        ball_y = 10'd200;
        release_btn();
        check("flight_phase",      {29'b0, phase},      32'd2);
        check("flight_attempts",   {24'b0, attempts},   32'd1);
        check("flight_engine_btn", {31'b0, engine_btn}, 32'd0);
        ball_y = 10'd250;
        step(1);
        check("below_rim_phase", {29'b0, phase}, 32'd2);
        ball_y = 10'd260;
        step(1);
        check("make_pulse",      {31'b0, score_pulse}, 32'd1);
        check("make_makes",      {24'b0, makes},       32'd1);
        check("make_phase",      {29'b0, phase},       32'd3);
        check("make_engine_rst", {31'b0, engine_rst},  32'd1);
        @(negedge clk);
        check("make_pulse_width", {31'b0, score_pulse}, 32'd0);
        step(HOLD_TICKS - 1);
        check("hold_phase",      {29'b0, phase},      32'd3);
        check("hold_engine_rst", {31'b0, engine_rst}, 32'd1);
        step(1);
        check("post_hold_phase",      {29'b0, phase},      32'd0);
        check("post_hold_engine_rst", {31'b0, engine_rst}, 32'd0);

        // Shot 2: rim-edge crossing is not a make, then engine_done
        ball_x = 10'd612;
        ball_y = 10'd200;
        press();
        release_btn();
        check("shot2_attempts", {24'b0, attempts}, 32'd2);
        ball_y = 10'd260;
        step(1);
        check("rim_edge_phase", {29'b0, phase}, 32'd2);
        engine_done = 1'b1;
        step(1);
        engine_done = 1'b0;
        check("miss_phase",    {29'b0, phase},    32'd4);
        check("miss_makes",    {24'b0, makes},    32'd1);
        check("miss_attempts", {24'b0, attempts}, 32'd2);
        step(HOLD_TICKS);
        check("gameover_phase", {29'b0, phase}, 32'd5);
        step(3);
        check("gameover_hold_phase",    {29'b0, phase},    32'd5);
        check("gameover_hold_makes",    {24'b0, makes},    32'd1);
        check("gameover_hold_attempts", {24'b0, attempts}, 32'd2);
        press();
        check("newgame_phase",    {29'b0, phase},    32'd0);
        check("newgame_makes",    {24'b0, makes},    32'd0);
        check("newgame_attempts", {24'b0, attempts}, 32'd0);
        release_btn();
        check("newgame_release_phase", {29'b0, phase}, 32'd0);

        // Timeout: MISS exactly at flight tick SHOT_TICKS
        ball_x = 10'd0;
        ball_y = 10'd100;
        press();
        release_btn();
        step(SHOT_TICKS - 1);
        check("timeout_pre_phase", {29'b0, phase}, 32'd2);
        step(1);
        check("timeout_phase", {29'b0, phase}, 32'd4);
        step(HOLD_TICKS);
        check("timeout_idle_phase", {29'b0, phase}, 32'd0);

        // Score and engine_done on the same tick: score wins
        ball_x = 10'd620;
        ball_y = 10'd200;
        press();
        release_btn();
        ball_y      = 10'd300;
        engine_done = 1'b1;
        step(1);
        engine_done = 1'b0;
        check("prio_phase",    {29'b0, phase},       32'd3);
        check("prio_pulse",    {31'b0, score_pulse}, 32'd1);
        check("prio_makes",    {24'b0, makes},       32'd1);
        check("prio_attempts", {24'b0, attempts},    32'd2);
        step(HOLD_TICKS);
        check("prio_gameover_phase", {29'b0, phase}, 32'd5);
        press();
        check("prio_newgame_phase", {29'b0, phase}, 32'd0);
        release_btn();

        // Long hold in ARMED
        ball_x = 10'd0;
        ball_y = 10'd100;
        press();
        check("charge_armed_phase", {29'b0, phase}, 32'd1);
`ifdef AUTO_RELEASE_EN
        step(CHARGE_MAX - 1);
        check("charge_pre_phase", {29'b0, phase}, 32'd1);
        step(1);
        check("auto_rel_phase",      {29'b0, phase},      32'd2);
        check("auto_rel_engine_btn", {31'b0, engine_btn}, 32'd0);
        check("auto_rel_attempts",   {24'b0, attempts},   32'd1);
        step(20 - CHARGE_MAX);
        check("auto_rel_still_flight", {29'b0, phase}, 32'd2);
`else
        step(20);
        check("charge_hold_phase",      {29'b0, phase},      32'd1);
        check("charge_hold_engine_btn", {31'b0, engine_btn}, 32'd1);
        check("charge_hold_attempts",   {24'b0, attempts},   32'd0);
`endif

        // Reset mid-shot aborts everything
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_phase",      {29'b0, phase},      32'd0);
        check("midrst_attempts",   {24'b0, attempts},   32'd0);
        check("midrst_engine_rst", {31'b0, engine_rst}, 32'd1);
        rst = 1'b0;
        btn_raw = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shot_sequencer.md
Name: shot_sequencer

Overview:
- Top-level game controller for the basketball shot simulator.
- Generates the 60 Hz physics tick, debounces the shoot button, and drives the button and reset inputs of the kinematic engine.
- Watches ball screen coordinates to detect made baskets, and keeps makes/attempts counts for the display and score logic.
- Sits between board I/O (button, LEDs, 7-seg) and the kinematic engine.

Parameters:
- TICK_DIV, 1666667, clk cycles per physics tick (100 MHz → 60 Hz).
- DEB_TICKS, 3, consecutive equal tick samples needed to accept a button change.
- SHOT_TICKS, 600, maximum flight duration in ticks (10 s).
- HOLD_TICKS, 60, result display duration in ticks.
- MAX_SHOTS, 10, attempts per game.
- HOOP_X_L, 610, rim left screen x.
- HOOP_X_R, 630, rim right screen x.
- HOOP_Y, 256, rim plane screen y.
- CHARGE_MAX, 120, charge limit in ticks (optional feature only).

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- btn_raw  in  1  asynchronous push-button
- ball_x  in  10  engine ball screen x
- ball_y  in  10  engine ball screen y (grows downward)
- engine_done  in  1  engine returned to its start state (level)
- tick  out  1  one-clk physics enable pulse
- engine_btn  out  1  debounced button level to engine
- engine_rst  out  1  engine reset level
- score_pulse  out  1  one-clk pulse on a made basket
- makes  out  8  made baskets
- attempts  out  8  shots launched
- phase  out  3  FSM state encoding

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. All registers clear. Outputs: tick=0, engine_btn=0, engine_rst=1, score_pulse=0, makes=0, attempts=0, phase=IDLE.
- Tick generation:
  - Counter runs 0..TICK_DIV-1; tick=1 on the cycle the counter equals TICK_DIV-1, registered.
  - Period is exactly TICK_DIV clks. The counter runs in every state.
- Button path:
  - btn_raw passes through a 2-FF synchronizer, then is sampled only on tick.
  - btn_clean toggles after DEB_TICKS consecutive samples differing from the current value.
  - press/release are internal one-clk pulses, aligned to the tick cycle.
  - engine_btn = btn_clean in ARMED; 0 in all other states.
- FSM, all transitions evaluated on tick cycles only (phase encoding in parentheses):
  - IDLE (0): engine_rst=0. On press → ARMED.
  - ARMED (1): on release → FLIGHT, attempts+1 (saturating at 255), flight timer cleared.
  - FLIGHT (2):
    - Flight timer increments each tick. prev_y registers ball_y each tick.
    - Score condition: prev_y < HOOP_Y ≤ ball_y and HOOP_X_L+4 ≤ ball_x ≤ HOOP_X_R-4. When met: → SCORED, makes+1 (saturating), score_pulse=1 for that clk.
    - Otherwise, if engine_done=1 or timer == SHOT_TICKS-1: → MISS.
    - Score has priority over engine_done and timeout in the same tick.
  - SCORED (3) / MISS (4):
    - engine_rst=1, hold counter counts HOLD_TICKS ticks.
    - Then → GAME_OVER if attempts == MAX_SHOTS, else → IDLE.
  - GAME_OVER (5): engine_rst=1. On press: clear makes and attempts → IDLE.
- prev_y is loaded with ball_y on the ARMED→FLIGHT transition, so no false crossing occurs on the first flight tick.
- A press arriving during SCORED, MISS or FLIGHT is ignored and is not queued.
- rst asserted mid-flight aborts the shot; counters clear, attempts are not preserved.
- Unused phase encodings 6–7 → IDLE on the next tick.

Optional Feature:
- Macro: AUTO_RELEASE_EN.
- Defined: in ARMED, a charge counter counts ticks. On reaching CHARGE_MAX with the button still held:
  - Forced release: engine_btn drops to 0 and the FSM goes → FLIGHT, attempts+1.
  - The later physical release is ignored until the next IDLE.
- Undefined: ARMED persists indefinitely until a real release. The charge counter and CHARGE_MAX are not synthesized.

Test Plan:
- Tick timing (use TICK_DIV=10): after reset, tick pulses every 10 clks, 1 clk wide. Bouncy press (glitches of 1 tick) → no ARMED. Steady press of 3 ticks → phase=1.
- Made shot: press/release, then drive ball_x=620 and ball_y 250→260 across one tick → score_pulse once, makes=1, attempts=1, phase=3. engine_rst=1 for HOLD_TICKS, then phase=0.
- Rim-edge miss: crossing at ball_x=612, then engine_done=1 → phase=4, makes=0, attempts=1.
- Timeout and priority: no engine_done → MISS exactly at flight tick SHOT_TICKS. In a separate run, score crossing and engine_done on the same tick → SCORED.
- Game end: MAX_SHOTS=2, two misses → phase=5 with counters held. Next press → makes=0, attempts=0, phase=0.
- AUTO_RELEASE_EN with CHARGE_MAX=5: hold the button for 20 ticks → FLIGHT at charge tick 5, engine_btn=0, attempts=1. Without the macro → still ARMED at tick 20.
